// File: rtl/cp0_exc_unit_pkg.sv
// rtl/cp0_exc_unit_pkg.sv - CP0 register numbers, exception codes and field positions
package cp0_exc_unit_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  // SR: IM[15:10], EXL[1], IE[0]; Cause: BD[31], IP[15:10], ExcCode[6:2]
  localparam int SR_IM_LO       = 10;
  localparam int SR_EXL         = 1;
  localparam int SR_IE          = 0;
  localparam int CAUSE_BD       = 31;
  localparam int CAUSE_IP_LO    = 10;
  localparam int CAUSE_EXC_LO   = 2;

endpackage

// File: rtl/cp0_exc_unit.sv
// rtl/cp0_exc_unit.sv - M-stage CP0: SR/Cause/EPC/PRId, mfc0/mtc0/eret, interrupt and exception entry
module cp0_exc_unit
  import cp0_exc_unit_pkg::*;
#(
  parameter logic [31:0] PRID         = 32'h0000_4A37,
  parameter bit          EXC_PC_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPC,
  output logic [31:0] DOut
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd_q;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc_q;

  logic        int_pend;
  logic        exc_pend;
  logic [31:0] victim_pc;

  function automatic logic [31:0] align_pc(input logic [31:0] x);
    return EXC_PC_ALIGN ? {x[31:2], 2'b00} : x;
  endfunction

  assign int_pend  = (|(HWInt & im)) & ie & ~exl;
  assign exc_pend  = (ExcCodeIn != EXC_INT) & ~exl;
  assign IntReq    = int_pend | exc_pend;
  assign victim_pc = BD ? (PC - 32'd4) : PC;
  assign EPC       = epc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd_q     <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc_q    <= '0;
    end else begin
      ip <= HWInt;
      if (IntReq) begin
        // The M instruction is flushed, so its mtc0/eret never take effect.
        exl      <= 1'b1;
        bd_q     <= BD;
        exc_code <= int_pend ? EXC_INT : ExcCodeIn;
        epc_q    <= align_pc(victim_pc);
      end else begin
        if (WE && A == REG_SR) begin
          im  <= DIn[SR_IM_LO +: 6];
          exl <= DIn[SR_EXL];
          ie  <= DIn[SR_IE];
        end
        if (WE && A == REG_EPC)
          epc_q <= align_pc(DIn);
        // eret overrides a same-cycle SR write for EXL only
        if (EXLClr)
          exl <= 1'b0;
      end
    end
  end

  always_comb begin
    DOut = '0;
    case (A)
      REG_SR: begin
        DOut[SR_IM_LO +: 6] = im;
        DOut[SR_EXL]        = exl;
        DOut[SR_IE]         = ie;
      end
      REG_CAUSE: begin
        DOut[CAUSE_BD]          = bd_q;
        DOut[CAUSE_IP_LO +: 6]  = ip;
        DOut[CAUSE_EXC_LO +: 5] = exc_code;
      end
      REG_EPC:  DOut = epc_q;
      REG_PRID: DOut = PRID;
      default:  DOut = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb/tb_cp0_exc_unit.sv - directed self-checking bench for cp0_exc_unit
module tb_cp0_exc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] PC;
  logic        BD;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPC;
  logic [31:0] DOut;

  int n_cmp = 0;
  int n_bad = 0;

  cp0_exc_unit dut (
    .clk(clk), .reset(reset), .A(A), .DIn(DIn), .WE(WE), .PC(PC), .BD(BD),
    .ExcCodeIn(ExcCodeIn), .HWInt(HWInt), .EXLClr(EXLClr),
    .IntReq(IntReq), .EPC(EPC), .DOut(DOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    A = addr;
    #1;
    check(tag, DOut, exp);
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    A = addr; DIn = data; WE = 1'b1;
    step();
    WE = 1'b0; DIn = '0;
  endtask

  task automatic eret();
    EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; A = '0; DIn = '0; WE = 1'b0; PC = 32'h3000; BD = 1'b0;
    ExcCodeIn = '0; HWInt = '0; EXLClr = 1'b0;
    step(); step();
    reset = 1'b0;

    rd("rst_sr", 5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc", 5'd14, 32'h0);
    rd("rst_prid", 5'd15, 32'h0000_4A37);
    check("rst_intreq", {31'b0, IntReq}, 32'h0);

    // Interrupt entry with IM/IE enabled
    mtc0(5'd12, 32'h0000_FC01);
    HWInt = 6'b000100;
    #1 check("int_req", {31'b0, IntReq}, 32'h1);
    step();
    rd("int_sr", 5'd12, 32'h0000_FC03);
    rd("int_cause", 5'd13, 32'h0000_1000);
    rd("int_epc", 5'd14, 32'h0000_3000);
    check("int_masked", {31'b0, IntReq}, 32'h0);

    // RI in delay slot with IE=0
    HWInt = '0;
    eret();
    mtc0(5'd12, 32'h0000_FC00);
    ExcCodeIn = 5'd10; PC = 32'h3010; BD = 1'b1;
    #1 check("ri_req", {31'b0, IntReq}, 32'h1);
    step();
    ExcCodeIn = '0; BD = 1'b0;
    rd("ri_epc", 5'd14, 32'h0000_300C);
    rd("ri_cause", 5'd13, 32'h8000_0028);
    rd("ri_sr", 5'd12, 32'h0000_FC02);

    // eret with simultaneous SR write: EXL clears, IE taken from DIn
    A = 5'd12; DIn = 32'h0000_FC03; WE = 1'b1; EXLClr = 1'b1;
    step();
    WE = 1'b0; EXLClr = 1'b0;
    rd("eret_wins", 5'd12, 32'h0000_FC01);

    // Interrupt beats Ov in the same cycle
    HWInt = 6'b000100; ExcCodeIn = 5'd12; PC = 32'h3020;
    step();
    ExcCodeIn = '0;
    rd("prio_cause", 5'd13, 32'h0000_1000);
    rd("prio_epc", 5'd14, 32'h0000_3020);

    // Masked while EXL=1, pending HWInt fires after eret
    ExcCodeIn = 5'd4;
    #1 check("nest_mask", {31'b0, IntReq}, 32'h0);
    step();
    ExcCodeIn = '0;
    check("nest_epc", EPC, 32'h0000_3020);
    eret();
    check("refire_req", {31'b0, IntReq}, 32'h1);
    PC = 32'h3040;
    step();
    check("refire_epc", EPC, 32'h0000_3040);

    // Read-only Cause, aligned EPC write, unmapped read
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd("cause_ro", 5'd13, 32'h0000_1000);
    mtc0(5'd14, 32'h0000_3003);
    rd("epc_align", 5'd14, 32'h0000_3000);
    rd("unmapped", 5'd11, 32'h0);

    // mtc0 dropped during entry
    HWInt = '0;
    eret();
    ExcCodeIn = 5'd5; PC = 32'h3100;
    A = 5'd14; DIn = 32'h0000_1234; WE = 1'b1;
    step();
    WE = 1'b0; ExcCodeIn = '0;
    rd("we_drop_epc", 5'd14, 32'h0000_3100);
    rd("we_drop_cause", 5'd13, 32'h0000_0014);

    // PC-4 wraps below zero
    eret();
    ExcCodeIn = 5'd12; PC = 32'h0; BD = 1'b1;
    step();
    ExcCodeIn = '0; BD = 1'b0;
    rd("wrap_epc", 5'd14, 32'hFFFF_FFFC);
    rd("wrap_cause", 5'd13, 32'h8000_0030);

    // Reset wins over an entry cycle
    eret();
    ExcCodeIn = 5'd4; PC = 32'h3200; reset = 1'b1;
    step();
    reset = 1'b0; ExcCodeIn = '0;
    rd("rst_entry_sr", 5'd12, 32'h0);
    rd("rst_entry_epc", 5'd14, 32'h0);
    rd("rst_entry_cause", 5'd13, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
- Coprocessor-0 block at the M stage of the pipelined MIPS core.
- Consumes the exception code carried down the pipeline, including RI (10) raised by the D-stage legality decoder when it flags an illegal instruction.
- Also consumes the six hardware interrupt lines.
- Holds SR/Cause/EPC/PRId, serves mfc0/mtc0/eret, and raises the request that flushes the pipeline and redirects fetch to the handler at 0x0000_4180.

Parameters:
- PRID, 32'h0000_4A37, constant value returned on reads of register 15.
- EXC_PC_ALIGN, 1, when 1 the two LSBs of the saved EPC are forced to 0.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- A  in  5  CP0 register number (rd field of mfc0/mtc0).
- DIn  in  32  write data for mtc0 (GPR[rt] forwarded to M).
- WE  in  1  mtc0 in M stage, valid this cycle.
- PC  in  32  PC of the instruction currently in M (victim PC).
- BD  in  1  M-stage instruction sits in a branch delay slot.
- ExcCodeIn  in  5  exception code carried to M; 0 means none.
- HWInt  in  6  hardware interrupt lines, level-sensitive.
- EXLClr  in  1  eret in M stage.
- IntReq  out  1  take interrupt/exception this cycle (combinational).
- EPC  out  32  current EPC register, used as the eret target.
- DOut  out  32  combinational read of register A.

Behaviour:
- State registers: IM[5:0] (SR[15:10]), EXL (SR[1]), IE (SR[0]), BDr (Cause[31]), IP[5:0] (Cause[15:10]), ExcCode[4:0] (Cause[6:2]), EPC[31:0].
- Reset (reset=1 at edge): all state is 0. IntReq=0 and EPC=0 after reset. DOut follows A (PRId read still returns PRID).
- IntPend = |(HWInt & IM) & IE & ~EXL.
- ExcPend = (ExcCodeIn != 0) & ~EXL.
- IntReq = IntPend | ExcPend. Zero latency, purely combinational.
- IP <= HWInt every cycle, unconditionally, including entry cycles.
- Entry cycle (IntReq=1):
  - EXL<=1, BDr<=BD.
  - ExcCode <= IntPend ? 0 : ExcCodeIn. An interrupt has priority over a synchronous exception in the same cycle.
  - EPC <= BD ? PC-4 : PC, then low 2 bits cleared if EXC_PC_ALIGN.
  - WE and EXLClr are ignored in the entry cycle; the M instruction is flushed.
- Non-entry cycle:
  - WE=1: A=12 writes IM<=DIn[15:10], EXL<=DIn[1], IE<=DIn[0]. A=14 writes EPC<=DIn (aligned if EXC_PC_ALIGN). Writes to any other address are dropped; Cause and PRId are read-only.
  - EXLClr=1: EXL<=0. If WE to SR occurs in the same cycle, EXLClr wins for EXL; the other SR bits take DIn.
- Reads (DOut):
  - A=12 gives {16'b0, IM, 8'b0, EXL, IE}.
  - A=13 gives {BDr, 15'b0, IP, 3'b0, ExcCode, 2'b0}.
  - A=14 gives EPC.
  - A=15 gives PRID.
  - Any other address gives 0.
  - Reads show the pre-edge value; there is no write-through bypass.
- Nesting: while EXL=1, all new requests are masked. A pending HWInt fires on the first cycle after EXL clears if IE and IM still allow it.
- Reset asserted during an entry cycle: reset wins and all state is 0 at the edge.
- PC-4 uses a 32-bit wrap: PC=0 with BD=1 gives 0xFFFF_FFFC, cleared to 0xFFFF_FFFC.

Decomposition:
- Shared package/define file holds:
  - CP0 register numbers SR=12, CAUSE=13, EPC=14, PRID=15.
  - ExcCode constants Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
  - Handler address 32'h0000_4180.
  - Field bit positions for SR and Cause.
- Single module. No sub-module is warranted; priority logic is two gates.

Test Plan:
- reset=1 for 2 cycles, then read A=12/13/14/15: DOut must be 0, 0, 0, 32'h0000_4A37, and IntReq=0.
- mtc0 A=12 DIn=32'h0000_FC01, then HWInt=6'b000100: IntReq=1 that cycle. Next cycle SR reads 0x0000_FC03, ExcCode=0, IP=6'b000100, and IntReq=0 because EXL masks it.
- ExcCodeIn=10 (RI), PC=0x3010, BD=1, IE=0: IntReq=1. After the edge, EPC=0x300C, Cause=0x8000_0028, EXL=1.
- HWInt[2] set with IM/IE enabled and ExcCodeIn=12 at PC=0x3020 in the same cycle: ExcCode=0, EPC=0x3020.
- EXL=1 with ExcCodeIn=4 applied: IntReq=0 and EPC unchanged. Then EXLClr=1 while HWInt stays asserted: IntReq=1 in the cycle after the eret edge.
- mtc0 A=13 DIn=0xFFFF_FFFF: Cause stays unchanged. mtc0 A=14 DIn=0x0000_3003: EPC reads 0x0000_3000. WE=1 with IntReq=1 in the same cycle: the write is dropped.
